// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

    // Controller states; encoding is fixed so other blocks and debug tools can decode it.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Default operand width.
    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width for a given operand width (at least one bit).
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    // Bit-counter width at the default operand width.
    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder used as the serial adder's datapath cell.
// Latency: zero cycles (purely combinational).
// Backpressure: none; outputs always follow inputs.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Latency: start accepted at E0, result registered at E0+WIDTH, done high the cycle after.
// Backpressure: start is ignored while busy; no abort except rst.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    bit_cnt;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_sr_next;

    // The single adder cell always looks at the current LSBs and the running carry.
    fa_cell u_fa_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 holds the first computed bit.
    assign sum_sr_next = {fa_s, sum_sr[WIDTH-1:1]};

    // Controller, datapath shift registers and registered outputs in one sequential block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry   <= cin;
                        bit_cnt <= '0;
                        sum_sr  <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry   <= fa_cout;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    sum_sr  <= sum_sr_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        // Result registers move only here, so partial sums never leak out.
                        sum   <= sum_sr_next;
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 against an arithmetic reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int failures = 0;

    // Reference result held by the bench: what sum/cout must show between completions.
    logic [W:0] ref_result = '0;

    // Observations gathered by do_add.
    int         run_busy_cnt;
    int         run_done_cnt;
    int         run_hold_bad;
    int         run_overlap;
    logic       done_end;
    logic       busy_end;
    logic       done_after;
    logic [W:0] res_end;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Issue one start pulse and observe the whole operation; optionally scramble inputs during RUN.
    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit disturb);
        run_busy_cnt = 0;
        run_done_cnt = 0;
        run_hold_bad = 0;
        run_overlap  = 0;
        @(negedge clk);
        a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            if (busy) run_busy_cnt++;
            if (done) run_done_cnt++;
            if (busy && done) run_overlap++;
            if ({cout, sum} !== ref_result) run_hold_bad++;
            if (disturb) begin
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom);
                start = 1'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        done_end = done;
        busy_end = busy;
        res_end = {cout, sum};
        ref_result = model_add(x, y, c);
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_result = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h want=00", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b want=0", cout); end
    endtask

    task automatic test_zero_add();
        do_add(8'h00, 8'h00, 1'b0, 0);
        checks++; if (run_busy_cnt !== W) begin failures++; $display("FAIL zero_busy_cycles got=%0d want=%0d", run_busy_cnt, W); end
        checks++; if (run_done_cnt !== 0) begin failures++; $display("FAIL zero_early_done got=%0d want=0", run_done_cnt); end
        checks++; if ({done_end, busy_end, done_after} !== 3'b100) begin failures++; $display("FAIL zero_done_strobe got=%b want=100", {done_end, busy_end, done_after}); end
        checks++; if (res_end !== 9'h000) begin failures++; $display("FAIL zero_result got=%h want=000", res_end); end
    endtask

    task automatic test_full_ripple();
        // Seed a nonzero visible result first so the hold check below is meaningful.
        do_add(8'h12, 8'h34, 1'b0, 0);
        checks++; if (res_end !== 9'h046) begin failures++; $display("FAIL seed_result got=%h want=046", res_end); end
        do_add(8'hFF, 8'h01, 1'b0, 0);
        checks++; if (run_hold_bad !== 0) begin failures++; $display("FAIL ripple_hold got=%0d changed cycles want=0", run_hold_bad); end
        checks++; if (done_end !== 1'b1) begin failures++; $display("FAIL ripple_done got=%b want=1", done_end); end
        checks++; if (res_end !== 9'h100) begin failures++; $display("FAIL ripple_result got=%h want=100", res_end); end
    endtask

    task automatic test_mixed_disturb();
        do_add(8'h5A, 8'h33, 1'b1, 1);
        checks++; if (run_busy_cnt !== W) begin failures++; $display("FAIL mixed_busy_cycles got=%0d want=%0d", run_busy_cnt, W); end
        checks++; if (run_hold_bad !== 0) begin failures++; $display("FAIL mixed_hold got=%0d want=0", run_hold_bad); end
        checks++; if ({done_end, done_after} !== 2'b10) begin failures++; $display("FAIL mixed_done_strobe got=%b want=10", {done_end, done_after}); end
        checks++; if (res_end !== 9'h08E) begin failures++; $display("FAIL mixed_result got=%h want=08E", res_end); end
    endtask

    task automatic test_back_to_back();
        int idx;
        int first_idx;
        int second_idx;
        int overlap;
        logic [W:0] first_res;
        logic [W:0] second_res;
        first_idx = -1; second_idx = -1; overlap = 0;
        first_res = '0; second_res = '0;
        @(negedge clk);
        a = 8'h5A; b = 8'h33; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        idx = 0;
        while (idx < 3 * (W + 1) && second_idx < 0) begin
            @(negedge clk);
            if (busy && done) overlap++;
            if (done) begin
                if (first_idx < 0) begin
                    first_idx = idx;
                    first_res = {cout, sum};
                    a = 8'hFF; b = 8'hFF; cin = 1'b1;
                end else begin
                    second_idx = idx;
                    second_res = {cout, sum};
                    start = 1'b0;
                end
            end
            idx++;
        end
        start = 1'b0;
        ref_result = model_add(8'hFF, 8'hFF, 1'b1);
        checks++; if (first_idx !== W) begin failures++; $display("FAIL b2b_first_latency got=%0d want=%0d", first_idx, W); end
        checks++; if (second_idx - first_idx !== W + 1) begin failures++; $display("FAIL b2b_spacing got=%0d want=%0d", second_idx - first_idx, W + 1); end
        checks++; if (first_res !== 9'h08E) begin failures++; $display("FAIL b2b_first_result got=%h want=08E", first_res); end
        checks++; if (second_res !== 9'h1FF) begin failures++; $display("FAIL b2b_second_result got=%h want=1FF", second_res); end
        checks++; if (overlap !== 0) begin failures++; $display("FAIL b2b_busy_done_overlap got=%0d want=0", overlap); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int late_done;
        late_done = 0;
        @(negedge clk);
        a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({busy, done, cout, sum} !== 11'b0) begin failures++; $display("FAIL midrst_outputs got=%b_%b_%b_%h want=0_0_0_00", busy, done, cout, sum); end
        @(negedge clk);
        rst = 1'b0;
        ref_result = '0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        checks++; if (late_done !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d active cycles want=0", late_done); end
        do_add(8'h81, 8'h7E, 1'b1, 0);
        checks++; if ({run_busy_cnt, done_end} !== {W, 1'b1}) begin failures++; $display("FAIL midrst_restart_timing got=busy%0d/done%b want=busy%0d/done1", run_busy_cnt, done_end, W); end
        checks++; if (res_end !== 9'h100) begin failures++; $display("FAIL midrst_restart_result got=%h want=100", res_end); end
    endtask

    task automatic test_random();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        logic [W:0]   exp_res;
        for (int n = 0; n < 24; n++) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            exp_res = model_add(x, y, c);
            do_add(x, y, c, bit'($urandom_range(0, 1)));
            checks++;
            if (res_end !== exp_res || run_hold_bad != 0 || run_overlap != 0 || done_end !== 1'b1 || done_after !== 1'b0 || run_busy_cnt != W) begin
                failures++;
                $display("FAIL random_%0d got=%h done=%b/%b hold=%0d busy=%0d want=%h done=1/0 hold=0 busy=%0d",
                         n, res_end, done_end, done_after, run_hold_bad, run_busy_cnt, exp_res, W);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_add();
        test_full_ripple();
        test_mixed_disturb();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
